attack_coord_ctrl: RTL and testbench
====================================

# attack_coord_ctrl

Controller for attack-coordinate entry. The player steps a column (shown as a letter) and a row (shown as a digit) with three buttons, and the block hands the confirmed pair to the game-state logic over a REQ/ACK handshake. It also time-shares the single 3-bit column/row 7-segment decoder between the two display digits, and blinks the field currently being edited. It sits between the debounced button inputs and the shared decoder plus the game-state logic.

## Interface
- NCOL, 5: number of selectable columns, 1..8; values 0..NCOL-1.
- NROW, 5: number of selectable rows, 1..8; values 0..NROW-1.
- SCAN_DIV, 1000: clock cycles per display digit slot, ≥2.
- BLINK_DIV, 64: digit slots per blink half-period, ≥1.

Ports:
- CLK  in  1  system clock; the single clock, all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- BTN_NEXT  in  1  level; debounced and synchronized upstream; rising edge = increment.
- BTN_OK  in  1  level; rising edge = confirm current field.
- BTN_BACK  in  1  level; rising edge = return to column edit.
- ACK  in  1  game-state logic has consumed the coordinate.
- COL  out  3  selected column; bit 2 drives decoder input A (MSB), bit 0 drives C.
- ROW  out  3  selected row.
- REQ  out  1  coordinate valid, held until ACK.
- DEC_IN  out  3  value routed to the shared decoder for the active digit.
- DIG_EN  out  2  one-hot digit enable; bit0 = column digit, bit1 = row digit.
- BLANK  out  1  active digit must be blanked (blink off phase).
- STATE  out  2  current FSM state, for debug.

## Operation
- Edge detection per button: press = BTN & ~prev. Each prev register resets to 1, so a button held through reset produces no press.
- Simultaneous presses in one cycle: priority BACK > OK > NEXT. Only one press is acted on per cycle.
- FSM states and encodings: S_COL=00, S_ROW=01, S_REQ=10. Encoding 11 is illegal and recovers to S_COL.
  - S_COL:
    - NEXT: COL = (COL==NCOL-1) ? 0 : COL+1.
    - OK: go to S_ROW.
    - BACK: no effect.
  - S_ROW:
    - NEXT: ROW wraps at NROW-1 in the same way.
    - OK: go to S_REQ and set REQ=1.
    - BACK: go to S_COL; ROW is kept.
  - S_REQ:
    - All buttons are ignored.
    - ACK=1 sampled: clear REQ, go to S_COL, and clear COL and ROW to 0.
- ACK outside S_REQ is ignored.
- Display scan:
  - Scan counter runs 0..SCAN_DIV-1. At wrap, DIG_EN toggles between 01 and 10.
  - Blink counter runs 0..BLINK_DIV-1 and advances on each scan wrap. At its wrap, the blink phase toggles.
- DEC_IN = COL when DIG_EN=01, otherwise ROW.
- BLANK = phase=1 AND the active digit is the field being edited (COL digit in S_COL, ROW digit in S_ROW). BLANK is never asserted in S_REQ.
- Counter widths are $clog2 of their modulus, minimum 1 bit. COL and ROW are zero-extended to 3 bits.

## Timing
- Reset values (visible after the first edge with RST=1):
  - COL=0, ROW=0, REQ=0, STATE=S_COL.
  - DIG_EN=01, DEC_IN=0, BLANK=0.
  - Scan counter 0, blink counter 0, phase 0.
- Press: BTN=0 at edge n-1 and BTN=1 at edge n. COL, ROW, STATE and REQ update at edge n.
- DEC_IN and BLANK are registered from the post-edge-n COL/ROW/STATE/DIG_EN, so they update at edge n+1.
- REQ rises at the OK edge in S_ROW.
- If ACK=1 at edge m, REQ=0 and STATE=S_COL after edge m. ACK already high on entry is accepted at the next edge.
- DIG_EN toggles every SCAN_DIV cycles. Blink phase toggles every SCAN_DIV·BLINK_DIV cycles.
- RST mid-handshake: REQ drops at that edge and no coordinate is retained.
- RST has priority over all inputs.

## Structure
- Package attack_ctrl_pkg holds:
  - state encodings S_COL/S_ROW/S_REQ;
  - digit one-hot constants DIG_COL=2'b01, DIG_ROW=2'b10;
  - width of COL/ROW (3).
- Sub-module btn_edge (prev register plus press pulse, reset prev=1) is instantiated three times.
- The FSM, selection registers and scan/blink counters are in the top module.

## Test plan
Benches use NCOL=5, NROW=5, SCAN_DIV=4, BLINK_DIV=2.
- Reset with BTN_NEXT held high: after release and re-press, COL=1. No press is counted during or at the end of reset.
- 5 NEXT presses in S_COL: COL goes 1,2,3,4,0. OK, then 3 NEXT: STATE=01, ROW=3.
- OK in S_ROW with COL=2, ROW=3: REQ=1 on the same edge. Buttons pressed while waiting leave COL/ROW unchanged.
- ACK after 5 cycles: REQ=0, STATE=00, COL=0, ROW=0 on the next edge. ACK pulsed in S_COL has no effect.
- BTN_BACK and BTN_NEXT rise in the same cycle in S_ROW: STATE=S_COL and ROW is unchanged.
- Scan with COL=4, ROW=1 in S_COL:
  - DIG_EN alternates every 4 cycles; DEC_IN alternates 4/1.
  - BLANK=1 only on the column slots during the phase=1 window (cycles 8..15 of each 16).

Source files
------------

// File: rtl/attack_ctrl_pkg.sv
// Shared types and constants for the attack-coordinate entry controller.
package attack_ctrl_pkg;

    localparam int unsigned CRW = 3;

    typedef enum logic [1:0] {
        S_COL = 2'b00,
        S_ROW = 2'b01,
        S_REQ = 2'b10
    } state_t;

    localparam logic [1:0] DIG_COL = 2'b01;
    localparam logic [1:0] DIG_ROW = 2'b10;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button; prev resets high so a
// button held through reset never registers as a press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_c
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= btn;
    end

    assign press_c = btn & ~prev;

endmodule

// File: rtl/attack_coord_ctrl.sv
// Column/row coordinate entry with REQ/ACK hand-off, plus time-shared
// digit scanning and blinking of the field being edited.
module attack_coord_ctrl
    import attack_ctrl_pkg::*;
#(
    parameter int unsigned NCOL      = 5,
    parameter int unsigned NROW      = 5,
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_next,
    input  logic           btn_ok,
    input  logic           btn_back,
    input  logic           ack,
    output logic [CRW-1:0] col,
    output logic [CRW-1:0] row,
    output logic           req,
    output logic [CRW-1:0] dec_in,
    output logic [1:0]     dig_en,
    output logic           blank,
    output logic [1:0]     state
);

    localparam int unsigned SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic next_c, ok_c, back_c;

    btn_edge u_next (.clk(clk), .rst(rst), .btn(btn_next), .press_c(next_c));
    btn_edge u_ok   (.clk(clk), .rst(rst), .btn(btn_ok),   .press_c(ok_c));
    btn_edge u_back (.clk(clk), .rst(rst), .btn(btn_back), .press_c(back_c));

    state_t         cur, nxt;
    logic [CRW-1:0] col_nxt, row_nxt;
    logic           req_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_COL;
            col <= '0;
            row <= '0;
            req <= 1'b0;
        end else begin
            cur <= nxt;
            col <= col_nxt;
            row <= row_nxt;
            req <= req_nxt;
        end
    end

    // Press priority is BACK > OK > NEXT; only the winner acts.
    always_comb begin
        nxt     = cur;
        col_nxt = col;
        row_nxt = row;
        req_nxt = req;
        case (cur)
            S_COL: begin
                if (!back_c) begin
                    if (ok_c)
                        nxt = S_ROW;
                    else if (next_c)
                        col_nxt = (col == CRW'(NCOL - 1)) ? '0 : col + CRW'(1);
                end
            end
            S_ROW: begin
                if (back_c)
                    nxt = S_COL;
                else if (ok_c) begin
                    nxt     = S_REQ;
                    req_nxt = 1'b1;
                end else if (next_c)
                    row_nxt = (row == CRW'(NROW - 1)) ? '0 : row + CRW'(1);
            end
            S_REQ: begin
                if (ack) begin
                    nxt     = S_COL;
                    req_nxt = 1'b0;
                    col_nxt = '0;
                    row_nxt = '0;
                end
            end
            default: begin
                nxt     = S_COL;
                req_nxt = 1'b0;
            end
        endcase
    end

    assign state = cur;

    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    // Digit scan, blink phase, and decoder/blank outputs one cycle behind selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            dig_en    <= DIG_COL;
            dec_in    <= '0;
            blank     <= 1'b0;
        end else begin
            dec_in <= (dig_en == DIG_COL) ? col : row;
            blank  <= phase & (((cur == S_COL) && (dig_en == DIG_COL)) ||
                               ((cur == S_ROW) && (dig_en == DIG_ROW)));
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                dig_en   <= ~dig_en;
                if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_attack_coord_ctrl.sv
// Self-checking bench for attack_coord_ctrl: directed vector table, corner
// sequences and randomized stimulus against a behavioural model.
module tb_attack_coord_ctrl;

    localparam int NC = 5;
    localparam int NR = 5;
    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0, btn_ok = 1'b0, btn_back = 1'b0, ack = 1'b0;
    logic [2:0] col, row, dec_in;
    logic       req, blank;
    logic [1:0] dig_en, state;

    attack_coord_ctrl #(.NCOL(NC), .NROW(NR), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_ok(btn_ok),
        .btn_back(btn_back), .ack(ack), .col(col), .row(row), .req(req),
        .dec_in(dec_in), .dig_en(dig_en), .blank(blank), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    // Behavioural model: mode 0=column edit, 1=row edit, 2=waiting for ack.
    int m_col = 0, m_row = 0, m_mode = 0, m_req = 0, m_k = 0;
    int m_dec = 0, m_blank = 0;
    bit pn = 1, po = 1, pb = 1;

    task automatic model_edge();
        int digit, ph;
        bit en, eo, eb;
        if (rst) begin
            m_col = 0; m_row = 0; m_mode = 0; m_req = 0; m_k = 0;
            m_dec = 0; m_blank = 0; pn = 1; po = 1; pb = 1;
        end else begin
            digit   = (m_k / SD) % 2;
            ph      = (m_k / (SD * BD)) % 2;
            m_dec   = (digit == 0) ? m_col : m_row;
            m_blank = (ph == 1 && ((m_mode == 0 && digit == 0) ||
                                   (m_mode == 1 && digit == 1))) ? 1 : 0;
            m_k++;
            en = btn_next && !pn; eo = btn_ok && !po; eb = btn_back && !pb;
            pn = btn_next; po = btn_ok; pb = btn_back;
            if (m_mode == 0) begin
                if (eb) ;
                else if (eo) m_mode = 1;
                else if (en) m_col = (m_col + 1) % NC;
            end else if (m_mode == 1) begin
                if (eb) m_mode = 0;
                else if (eo) begin m_mode = 2; m_req = 1; end
                else if (en) m_row = (m_row + 1) % NR;
            end else if (ack) begin
                m_mode = 0; m_req = 0; m_col = 0; m_row = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("col",    int'(col),    m_col);
        chk("row",    int'(row),    m_row);
        chk("state",  int'(state),  m_mode);
        chk("req",    int'(req),    m_req);
        chk("dig_en", int'(dig_en), ((m_k / SD) % 2 == 1) ? 2 : 1);
        chk("dec_in", int'(dec_in), m_dec);
        chk("blank",  int'(blank),  m_blank);
    endtask

    task automatic drive(input bit n, input bit o, input bit b, input bit a);
        btn_next = n; btn_ok = o; btn_back = b; ack = a;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    typedef struct packed {
        logic n, o, b, a;
        logic [2:0] c, r;
        logic [1:0] s;
        logic q;
    } vec_t;

    function automatic vec_t mk(input bit n, input bit o, input bit b, input bit a,
                                input int c, input int r, input int s, input bit q);
        vec_t v;
        v.n = n; v.o = o; v.b = b; v.a = a;
        v.c = 3'(c); v.r = 3'(r); v.s = 2'(s); v.q = q;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // n o b a | col row state req
        tbl.push_back(mk(0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 1,0,0,0)); tbl.push_back(mk(0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0, 2,0,0,0)); tbl.push_back(mk(0,0,0,0, 2,0,0,0));
        tbl.push_back(mk(1,0,0,0, 3,0,0,0)); tbl.push_back(mk(0,0,0,0, 3,0,0,0));
        tbl.push_back(mk(1,0,0,0, 4,0,0,0)); tbl.push_back(mk(0,0,0,0, 4,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0)); tbl.push_back(mk(0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1,0)); tbl.push_back(mk(0,0,0,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0,0, 0,1,1,0)); tbl.push_back(mk(0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(1,0,0,0, 0,2,1,0)); tbl.push_back(mk(0,0,0,0, 0,2,1,0));
        tbl.push_back(mk(1,0,0,0, 0,3,1,0)); tbl.push_back(mk(0,0,0,0, 0,3,1,0));
        tbl.push_back(mk(0,0,1,0, 0,3,0,0)); tbl.push_back(mk(0,0,0,0, 0,3,0,0));
        tbl.push_back(mk(1,0,0,0, 1,3,0,0)); tbl.push_back(mk(0,0,0,0, 1,3,0,0));
        tbl.push_back(mk(1,0,0,0, 2,3,0,0)); tbl.push_back(mk(0,0,0,0, 2,3,0,0));
        tbl.push_back(mk(0,1,0,0, 2,3,1,0)); tbl.push_back(mk(0,0,0,0, 2,3,1,0));
        tbl.push_back(mk(0,1,0,0, 2,3,2,1)); tbl.push_back(mk(0,0,0,0, 2,3,2,1));
        tbl.push_back(mk(1,0,0,0, 2,3,2,1)); tbl.push_back(mk(0,1,1,0, 2,3,2,1));
        tbl.push_back(mk(0,0,0,0, 2,3,2,1)); tbl.push_back(mk(0,0,0,0, 2,3,2,1));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0)); tbl.push_back(mk(0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0)); tbl.push_back(mk(0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,1,0)); tbl.push_back(mk(0,0,0,0, 0,0,1,0));
        tbl.push_back(mk(1,0,0,0, 0,1,1,0)); tbl.push_back(mk(0,0,0,0, 0,1,1,0));
        tbl.push_back(mk(1,0,1,0, 0,1,0,0)); tbl.push_back(mk(0,0,0,0, 0,1,0,0));
        tbl.push_back(mk(1,1,1,0, 0,1,0,0)); tbl.push_back(mk(0,0,0,0, 0,1,0,0));

        // Button held through reset must not count as a press.
        drive(1, 0, 0, 0);
        do_reset();
        chk("rst_col",    int'(col),    0);
        chk("rst_state",  int'(state),  0);
        chk("rst_req",    int'(req),    0);
        chk("rst_dig_en", int'(dig_en), 1);
        chk("rst_dec_in", int'(dec_in), 0);
        chk("rst_blank",  int'(blank),  0);
        tick();
        chk("held_no_press", int'(col), 0);
        drive(0, 0, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        chk("repress_col", int'(col), 1);

        // Directed vector table.
        drive(0, 0, 0, 0);
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].n, tbl[i].o, tbl[i].b, tbl[i].a);
            tick();
            chk($sformatf("vec%0d_col", i),   int'(col),   int'(tbl[i].c));
            chk($sformatf("vec%0d_row", i),   int'(row),   int'(tbl[i].r));
            chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].s));
            chk($sformatf("vec%0d_req", i),   int'(req),   int'(tbl[i].q));
        end

        // Scan/blink with COL=4, ROW=1 in column edit, from a fresh reset.
        drive(0, 0, 0, 0);
        do_reset();
        tick();
        drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0); tick();
        drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0); tick();
        drive(0, 0, 1, 0); tick(); drive(0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0); tick(); drive(0, 0, 0, 0); tick();
        end
        chk("scan_col", int'(col), 4);
        chk("scan_row", int'(row), 1);
        for (int i = 0; i < 40; i++) tick();

        // Reset in the middle of a handshake drops REQ and the coordinate.
        drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick(); drive(0, 0, 0, 0); tick();
        chk("hs_req", int'(req), 1);
        drive(0, 0, 0, 1);
        do_reset();
        chk("hs_rst_req", int'(req), 0);
        chk("hs_rst_col", int'(col), 0);
        chk("hs_rst_row", int'(row), 0);
        drive(0, 0, 0, 0);
        tick();

        // Randomized stimulus against the model, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
